// File: rtl/cmos_pattern_gen.sv
// rtl/cmos_pattern_gen.sv - synthetic CMOS camera source with programmable timing and RGB565 test patterns
// Optional CMOS_PATGEN_FRAME_ID_EN adds frame_id and stamps it into the first pixel of each frame.
module cmos_pattern_gen #(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int H_BLANK     = 256,
  parameter int VSYNC_LINES = 4,
  parameter int V_BACK      = 16,
  parameter int V_FRONT     = 4,
  parameter logic [15:0] SOLID_COLOR = 16'hF800
) (
  input  logic        cam_pclk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [15:0] cam_data,
  output logic        cam_data_valid,
  output logic        frame_done,
  output logic        busy
`ifdef CMOS_PATGEN_FRAME_ID_EN
  ,
  output logic [7:0]  frame_id
`endif
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [11:0] HA      = 12'(H_ACTIVE);
  localparam logic [11:0] L_LAST  = 12'(H_ACTIVE + H_BLANK - 1);
  localparam logic [11:0] VS_LAST = 12'(VSYNC_LINES - 1);
  localparam logic [11:0] VB_LAST = 12'(V_BACK - 1);
  localparam logic [11:0] VA_LAST = 12'(V_ACTIVE - 1);
  localparam logic [11:0] VF_LAST = 12'(V_FRONT - 1);
  localparam logic [11:0] BW_LAST = 12'(BAR_W - 1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

  state_t      state, state_n;
  logic [11:0] h_cnt, h_n, v_cnt, v_n;
  logic [11:0] bar_px, bar_px_n;
  logic [3:0]  bar_idx, bar_idx_n;
  logic [15:0] pix_cnt, pix_cnt_n;
  logic [1:0]  pat_q, pat_n;
  logic        line_end, end_frame, pix_act, done_n;
  logic [15:0] data_n;

  function automatic logic [15:0] bar_color(input logic [3:0] idx);
    case (idx)
      4'd0:    bar_color = 16'hFFFF;
      4'd1:    bar_color = 16'hFFE0;
      4'd2:    bar_color = 16'h07FF;
      4'd3:    bar_color = 16'h07E0;
      4'd4:    bar_color = 16'hF81F;
      4'd5:    bar_color = 16'hF800;
      4'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  endfunction

  // Counters describe the position of the cycle currently on the outputs;
  // the next position and its outputs are computed together and registered.
  always_comb begin
    state_n   = state;
    h_n       = h_cnt;
    v_n       = v_cnt;
    pat_n     = pat_q;
    end_frame = 1'b0;
    line_end  = (h_cnt == L_LAST);
    if (state == IDLE) begin
      if (enable) begin
        state_n = VSYNC;
        h_n     = '0;
        v_n     = '0;
        pat_n   = pattern_sel;
      end
    end else begin
      h_n = line_end ? 12'd0 : h_cnt + 12'd1;
      if (line_end) begin
        v_n = v_cnt + 12'd1;
        case (state)
          VSYNC: if (v_cnt == VS_LAST) begin
            v_n     = '0;
            state_n = (V_BACK == 0) ? ACTIVE : VBACK;
          end
          VBACK: if (v_cnt == VB_LAST) begin
            v_n     = '0;
            state_n = ACTIVE;
          end
          ACTIVE: if (v_cnt == VA_LAST) begin
            v_n = '0;
            if (V_FRONT == 0) end_frame = 1'b1;
            else              state_n   = VFRONT;
          end
          VFRONT: if (v_cnt == VF_LAST) end_frame = 1'b1;
          default: ;
        endcase
      end
      if (end_frame) begin
        v_n = '0;
        if (enable) begin
          state_n = VSYNC;
          pat_n   = pattern_sel;
        end else begin
          state_n = IDLE;
        end
      end
    end

    pix_act = (state_n == ACTIVE) && (h_n < HA);
    if (V_FRONT == 0)
      done_n = (state_n == ACTIVE) && (h_n == L_LAST) && (v_n == VA_LAST);
    else
      done_n = (state_n == VFRONT) && (h_n == L_LAST) && (v_n == VF_LAST);

    bar_px_n  = '0;
    bar_idx_n = '0;
    pix_cnt_n = pix_cnt;
    if (pix_act) begin
      if (h_n != 12'd0) begin
        if (bar_px == BW_LAST) begin
          bar_idx_n = bar_idx + 4'd1;
        end else begin
          bar_px_n  = bar_px + 12'd1;
          bar_idx_n = bar_idx;
        end
      end
      pix_cnt_n = (h_n == 12'd0 && v_n == 12'd0) ? 16'd0 : pix_cnt + 16'd1;
    end

    data_n = '0;
    if (pix_act) begin
      case (pat_n)
        2'd0:    data_n = (BAR_W == 0) ? 16'h0000 : bar_color(bar_idx_n);
        2'd1:    data_n = {h_n[4:0], h_n[5:0], h_n[4:0]};
        2'd2:    data_n = pix_cnt_n;
        default: data_n = SOLID_COLOR;
      endcase
`ifdef CMOS_PATGEN_FRAME_ID_EN
      if (h_n == 12'd0 && v_n == 12'd0) data_n = {8'hA5, frame_id};
`endif
    end
  end

  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      state          <= IDLE;
      h_cnt          <= '0;
      v_cnt          <= '0;
      bar_px         <= '0;
      bar_idx        <= '0;
      pix_cnt        <= '0;
      pat_q          <= '0;
      cam_vsync      <= 1'b0;
      cam_href       <= 1'b0;
      cam_data       <= '0;
      cam_data_valid <= 1'b0;
      frame_done     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_n;
      h_cnt          <= h_n;
      v_cnt          <= v_n;
      bar_px         <= bar_px_n;
      bar_idx        <= bar_idx_n;
      pix_cnt        <= pix_cnt_n;
      pat_q          <= pat_n;
      cam_vsync      <= (state_n == VSYNC);
      cam_href       <= pix_act;
      cam_data       <= data_n;
      cam_data_valid <= pix_act;
      frame_done     <= done_n;
      busy           <= (state_n != IDLE);
    end
  end

`ifdef CMOS_PATGEN_FRAME_ID_EN
  // frame_done is high on the last frame cycle, so the id steps as the frame closes.
  always_ff @(posedge cam_pclk) begin
    if (rst)             frame_id <= '0;
    else if (frame_done) frame_id <= frame_id + 8'd1;
  end
`endif

endmodule

// File: tb/tb_cmos_pattern_gen.sv
// tb/tb_cmos_pattern_gen.sv - self-checking bench for cmos_pattern_gen against a frame-time model
module tb_cmos_pattern_gen;
  localparam int HA = 66, VA = 4, HB = 4, VSL = 1, VB = 1, VF = 1;
  localparam int L  = HA + HB;
  localparam int FL = (VSL + VB + VA + VF) * L;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic        cam_vsync, cam_href, cam_data_valid, frame_done, busy;
  logic [15:0] cam_data;
`ifdef CMOS_PATGEN_FRAME_ID_EN
  logic [7:0]  frame_id;
`endif

  cmos_pattern_gen #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VSYNC_LINES(VSL),
    .V_BACK(VB), .V_FRONT(VF), .SOLID_COLOR(16'hF800)
  ) dut (
    .cam_pclk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .cam_data_valid(cam_data_valid), .frame_done(frame_done), .busy(busy)
`ifdef CMOS_PATGEN_FRAME_ID_EN
    , .frame_id(frame_id)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel value from the pattern rules, by pixel position (x, y) in the frame.
  function automatic logic [15:0] model_pixel(input logic [1:0] pat, input int x, input int y);
    logic [11:0] xv;
    int bar;
    xv  = 12'(x);
    bar = x / (HA / 8);
    case (pat)
      2'd0: begin
        case (bar)
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      2'd1:    return {xv[4:0], xv[5:0], xv[4:0]};
      2'd2:    return 16'(y * HA + x);
      default: return 16'hF800;
    endcase
  endfunction

  // Model: whether a frame is running, cycle index within it, latched pattern.
  logic       m_busy = 1'b0;
  int         m_t = 0;
  logic [1:0] m_pat = 2'd0;
  logic [7:0] m_fid = 8'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_t    <= 0;
      m_fid  <= 8'd0;
    end else if (!m_busy) begin
      if (enable) begin
        m_busy <= 1'b1;
        m_t    <= 0;
        m_pat  <= pattern_sel;
      end
    end else if (m_t == FL - 1) begin
      m_fid <= m_fid + 8'd1;
      if (enable) begin
        m_t   <= 0;
        m_pat <= pattern_sel;
      end else begin
        m_busy <= 1'b0;
      end
    end else begin
      m_t <= m_t + 1;
    end
  end

  // Per-cycle compare plus receiver-side edge checks.
  int   cyc = 0;
  int   vs_start = 0;
  int   vs_len = 0;
  int   href_falls = 0;
  logic prev_vs = 1'b0;
  logic prev_href = 1'b0;

  initial begin
    int line, h, y;
    logic evs, eact, edone;
    logic [15:0] edata;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      line  = m_t / L;
      h     = m_t % L;
      y     = line - VSL - VB;
      evs   = m_busy && (line < VSL);
      eact  = m_busy && (line >= VSL + VB) && (line < VSL + VB + VA) && (h < HA);
      edone = m_busy && (m_t == FL - 1);
      edata = eact ? model_pixel(m_pat, h, y) : 16'h0000;
`ifdef CMOS_PATGEN_FRAME_ID_EN
      if (eact && h == 0 && y == 0) edata = {8'hA5, m_fid};
      check("frame_id", {24'd0, frame_id}, {24'd0, m_fid});
`endif
      check("cycle_outputs",
            {11'd0, cam_vsync, cam_href, cam_data_valid, frame_done, busy, cam_data},
            {11'd0, evs, eact, eact, edone, m_busy, edata});

      if (cam_vsync && !prev_vs) begin
        vs_start   = cyc;
        vs_len     = 0;
        href_falls = 0;
      end
      if (cam_vsync) vs_len++;
      if (!cam_vsync && prev_vs) check("vsync_len", 32'(vs_len), 32'd70);
      if (prev_href && !cam_href) href_falls++;
      if (frame_done) begin
        check("href_falls_per_frame", 32'(href_falls), 32'd4);
        check("frame_len", 32'(cyc - vs_start), 32'd489);
      end
      prev_vs   = cam_vsync;
      prev_href = cam_href;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    step(3);
    check("pin_bar0", {16'd0, model_pixel(2'd0, 0, 0)}, 32'h0000FFFF);
    check("pin_bar1", {16'd0, model_pixel(2'd0, 8, 0)}, 32'h0000FFE0);
    check("pin_bar7", {16'd0, model_pixel(2'd0, 63, 0)}, 32'h00000000);
    check("pin_remainder", {16'd0, model_pixel(2'd0, 64, 0)}, 32'h00000000);
    check("pin_grad33", {16'd0, model_pixel(2'd1, 33, 0)}, 32'h00000C21);
    check("pin_grad63", {16'd0, model_pixel(2'd1, 63, 0)}, 32'h0000FFFF);
    check("pin_count", {16'd0, model_pixel(2'd2, 0, 1)}, 32'h00000042);
    check("pin_solid", {16'd0, model_pixel(2'd3, 5, 2)}, 32'h0000F800);
    rst = 1'b0;
    step(5);
    pattern_sel = 2'd2;
    enable = 1'b1;
    step(FL / 2);
    pattern_sel = 2'd3;
    step(FL);
    pattern_sel = 2'd0;
    step(FL);
    pattern_sel = 2'd1;
    step(FL);
    enable = 1'b0;
    step(FL);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_vsync", {31'd0, cam_vsync}, 32'd0);
    pattern_sel = 2'd2;
    enable = 1'b1;
    step(1);
    step(4 * L + 10);
    rst = 1'b1;
    step(1);
    check("abort_href", {31'd0, cam_href}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_data", {16'd0, cam_data}, 32'd0);
    rst = 1'b0;
    step(FL + 20);
    enable = 1'b0;
    step(FL + 10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
